// File: rtl/parallel_out_pkg.sv
// Shared definitions for the FIFO-backed parallel output port:
// register offsets, CTRL/STATUS bit positions and output FSM states.
package parallel_out_pkg;

  localparam logic [3:0] CTRL_OFF   = 4'h0;
  localparam logic [3:0] DATA_OFF   = 4'h4;
  localparam logic [3:0] STATUS_OFF = 4'h8;
  localparam logic [3:0] DELAY_OFF  = 4'hC;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_LEVEL = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PRESENT
  } out_state_e;

endpackage

// File: rtl/bus_if.sv
// Peripheral bus used by all SoC bus slaves.
// Single-cycle request, registered read response.
interface bus_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          gnt;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rdata, rvalid, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rdata, rvalid, err
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
// A push into a full FIFO is only taken when a pop happens too.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign rdata   = mem[rptr];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/parallel_out_fifo.sv
// Bus-slave parallel output port: write FIFO, programmable
// inter-word delay and valid/ready handoff to the consumer.
module parallel_out_fifo
  import parallel_out_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int DEPTH         = 8,
  parameter int DELAY_W       = 8,
  parameter int DEFAULT_DELAY = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  bus_if.slave              bus,
  output logic              parout_valid,
  output logic [DATA_W-1:0] parout,
  input  logic              parout_ready,
  output logic              irq_o
);
  localparam int LW = $clog2(DEPTH) + 1;

  out_state_e         state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [DELAY_W-1:0] delay_q;
  logic               enable_q;
  logic               irq_en_q;
  logic               ovf_q;
  logic [DATA_W-1:0]  last_q;

  logic               wr, rd;
  logic               sel_ctrl, sel_data;
  logic               sel_status, sel_delay;
  logic               flush, push, pop;
  logic [DATA_W-1:0]  head;
  logic               full, empty;
  logic [LW-1:0]      level;
  logic [31:0]        status;
  logic [31:0]        rd_mux;
  logic               unused_ok;

  assign bus.gnt   = bus.req;
  assign bus.err   = 1'b0;
  assign unused_ok = ^{bus.addr[31:4], bus.wdata};

  assign wr         = bus.req && bus.we;
  assign rd         = bus.req && !bus.we;
  assign sel_ctrl   = bus.addr[3:0] == CTRL_OFF;
  assign sel_data   = bus.addr[3:0] == DATA_OFF;
  assign sel_status = bus.addr[3:0] == STATUS_OFF;
  assign sel_delay  = bus.addr[3:0] == DELAY_OFF;

  assign flush = wr && sel_ctrl && bus.wdata[CTRL_FLUSH];
  assign push  = wr && sel_data;
  assign pop   = state_q == PRESENT && parout_ready && !flush;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (bus.wdata[DATA_W-1:0]),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign parout_valid = state_q == PRESENT;
  assign parout       = parout_valid ? head : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (enable_q && !empty) begin
          state_d = WAIT;
          cnt_d   = delay_q;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = PRESENT;
        else             cnt_d   = cnt_q - DELAY_W'(1);
      end
      PRESENT: begin
        if (parout_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    status             = '0;
    status[ST_EMPTY]   = empty;
    status[ST_FULL]    = full;
    status[ST_OVF]     = ovf_q;
    status[ST_LEVEL +: LW] = level;
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_ctrl: begin
        rd_mux[CTRL_EN]     = enable_q;
        rd_mux[CTRL_IRQ_EN] = irq_en_q;
      end
      sel_data:   rd_mux = 32'(last_q);
      sel_status: rd_mux = status;
      sel_delay:  rd_mux = 32'(delay_q);
      default:    rd_mux = '0;
    endcase
  end

  // Overflow only when the full FIFO is not popping this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      delay_q    <= DELAY_W'(DEFAULT_DELAY);
      last_q     <= '0;
      irq_o      <= 1'b0;
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
    end else begin
      if (wr && sel_ctrl) begin
        enable_q <= bus.wdata[CTRL_EN];
        irq_en_q <= bus.wdata[CTRL_IRQ_EN];
      end
      if (wr && sel_delay) delay_q <= bus.wdata[DELAY_W-1:0];
      if (wr && sel_status && bus.wdata[ST_OVF]) ovf_q <= 1'b0;
      else if (push && full && !pop)             ovf_q <= 1'b1;
      if (pop) last_q <= head;
      irq_o      <= irq_en_q && empty;
      bus.rvalid <= rd;
      bus.rdata  <= rd ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_parallel_out_fifo.sv
// Bench for parallel_out_fifo: directed scenarios plus random
// traffic scored against a queue model of the output port.
module tb_parallel_out_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          parout_valid;
  logic [DW-1:0] parout;
  logic          parout_ready = 1'b0;
  logic          irq_o;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  bus_if bus ();

  always #5 clk = ~clk;

  parallel_out_fifo #(
    .DATA_W        (DW),
    .DEPTH         (DEPTH),
    .DELAY_W       (8),
    .DEFAULT_DELAY (15)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .parout_valid (parout_valid),
    .parout       (parout),
    .parout_ready (parout_ready),
    .irq_o        (irq_o)
  );

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 32'(a);
    bus.wdata = d;
    tick();
    bus.req = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a,
                        input logic [31:0] exp);
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 32'(a);
    tick();
    bus.req = 1'b0;
    check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    check(tag, bus.rdata, exp);
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!parout_valid && n < max) begin
      tick();
      n++;
    end
    if (!parout_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] model_status(input int size,
                                               input logic ovf);
    logic [31:0] s;
    s       = '0;
    s[0]    = size == 0;
    s[1]    = size == DEPTH;
    s[2]    = ovf;
    s[15:8] = 8'(size);
    return s;
  endfunction

  logic [DW-1:0] q[$];
  logic [DW-1:0] w;
  logic [31:0]   exp_rd;
  logic          ovf_m, pend, hs, prev_v, prev_hs;
  logic [DW-1:0] prev_d;
  int            n, last, bad, seen, drops;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_valid", 32'(parout_valid), 32'd0);
    check("rst_parout", 32'(parout), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    rd_chk("rst_ctrl", 4'h0, 32'h0);
    rd_chk("rst_data", 4'h4, 32'h0);
    rd_chk("rst_status", 4'h8, 32'h1);
    rd_chk("rst_delay", 4'hC, 32'd15);

    bus_wr(4'h0, 32'h1);
    bus_wr(4'hC, 32'h0);
    parout_ready = 1'b1;
    bus_wr(4'h4, 32'hA5);
    wait_valid(50, n);
    check("lat_delay0", n + 1, 32'd3);
    check("word_a5", 32'(parout), 32'hA5);
    tick();
    check("one_cycle", 32'(parout_valid), 32'd0);
    rd_chk("last_a5", 4'h4, 32'hA5);
    rd_chk("empty_after", 4'h8, 32'h1);

    bus_wr(4'hC, 32'd4);
    bus_wr(4'h0, 32'h0);
    q.delete();
    for (int i = 0; i < 9; i++) begin
      w = DW'($urandom);
      bus_wr(4'h4, 32'(w));
      if (q.size() < DEPTH) q.push_back(w);
    end
    rd_chk("full_ovf", 4'h8, 32'h0806);
    bus_wr(4'h8, 32'h4);
    rd_chk("ovf_clear", 4'h8, 32'h0802);
    bus_wr(4'h0, 32'h1);
    last = 0;
    for (int i = 0; i < DEPTH; i++) begin
      wait_valid(100, n);
      check("order", 32'(parout), 32'(q.pop_front()));
      if (i > 0) check("spacing", cyc - last, 32'd7);
      last = cyc;
      tick();
    end
    rd_chk("drained", 4'h8, 32'h1);

    bus_wr(4'h0, 32'h5);
    check("irq_latency", 32'(irq_o), 32'd0);
    tick();
    check("irq_set", 32'(irq_o), 32'd1);
    bus_wr(4'h0, 32'h1);

    parout_ready = 1'b0;
    bus_wr(4'hC, 32'd2);
    w = DW'($urandom);
    bus_wr(4'h4, 32'(w));
    wait_valid(50, n);
    bad = 0;
    repeat (20) begin
      tick();
      if (!parout_valid || parout !== w) bad++;
    end
    check("stall_stable", bad, 32'd0);
    parout_ready = 1'b1;
    tick();
    parout_ready = 1'b0;
    check("single_pop", 32'(parout_valid), 32'd0);
    rd_chk("stall_empty", 4'h8, 32'h1);
    rd_chk("stall_last", 4'h4, 32'(w));

    bus_wr(4'h0, 32'h0);
    bus_wr(4'hC, 32'd0);
    q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      w = DW'($urandom);
      bus_wr(4'h4, 32'(w));
      q.push_back(w);
    end
    bus_wr(4'h0, 32'h1);
    wait_valid(50, n);
    check("full_head", 32'(parout), 32'(q[0]));
    w = DW'($urandom);
    parout_ready = 1'b1;
    bus_wr(4'h4, 32'(w));
    parout_ready = 1'b0;
    void'(q.pop_front());
    q.push_back(w);
    rd_chk("push_pop_full", 4'h8, 32'h0802);
    parout_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wait_valid(50, n);
      check("full_order", 32'(parout), 32'(q.pop_front()));
      tick();
    end

    bus_wr(4'hC, 32'd10);
    bus_wr(4'h4, 32'h3C);
    repeat (3) tick();
    bus_wr(4'h0, 32'h3);
    seen = 0;
    repeat (30) begin
      tick();
      if (parout_valid) seen++;
    end
    check("flush_no_out", seen, 32'd0);
    rd_chk("flush_empty", 4'h8, 32'h1);
    rd_chk("flush_ctrl", 4'h0, 32'h1);

    parout_ready = 1'b0;
    bus_wr(4'hC, 32'd1);
    bus_wr(4'h4, 32'h5A);
    wait_valid(50, n);
    rst = 1'b1;
    tick();
    check("rst_drop", 32'(parout_valid), 32'd0);
    rst = 1'b0;
    check("rst2_irq", 32'(irq_o), 32'd0);
    rd_chk("rst2_ctrl", 4'h0, 32'h0);
    rd_chk("rst2_data", 4'h4, 32'h0);
    rd_chk("rst2_status", 4'h8, 32'h1);
    rd_chk("rst2_delay", 4'hC, 32'd15);

    bus_wr(4'h0, 32'h1);
    bus_wr(4'hC, 32'($urandom_range(0, 3)));
    q.delete();
    ovf_m   = 1'b0;
    pend    = 1'b0;
    prev_v  = 1'b0;
    prev_hs = 1'b0;
    prev_d  = '0;
    drops   = 0;
    repeat (400) begin
      bus.req = 1'b0;
      bus.we  = 1'b0;
      if (pend) begin
        check("rnd_status", bus.rdata, exp_rd);
        pend = 1'b0;
      end
      if (prev_v && !prev_hs && (!parout_valid || parout !== prev_d))
        drops++;
      parout_ready = ($urandom % 10) < 3;
      exp_rd = model_status(q.size(), ovf_m);
      hs = parout_valid && parout_ready;
      if (hs) begin
        if (q.size() == 0) check("rnd_spurious", 32'd1, 32'd0);
        else check("rnd_word", 32'(parout), 32'(q.pop_front()));
      end
      n = $urandom % 10;
      if (n < 4) begin
        w         = DW'($urandom);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 32'h4;
        bus.wdata = 32'(w);
        if (q.size() < DEPTH) q.push_back(w);
        else ovf_m = 1'b1;
      end else if (n < 6) begin
        bus.req  = 1'b1;
        bus.addr = 32'h8;
        pend     = 1'b1;
      end
      prev_v  = parout_valid;
      prev_hs = hs;
      prev_d  = parout;
      tick();
    end
    bus.req = 1'b0;
    bus.we  = 1'b0;
    if (pend) check("rnd_status", bus.rdata, exp_rd);
    check("rnd_hold", drops, 32'd0);
    parout_ready = 1'b0;
    if (parout_valid && prev_v && !prev_hs) begin end
    rd_chk("rnd_final", 4'h8, model_status(q.size(), ovf_m));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/parallel_out_fifo.md
# parallel_out_fifo

Bus-slave parallel output port and the parametrised successor of the single-register parallel output peripheral. It has:
- a configurable data width;
- a write FIFO, so software can queue several words without polling;
- a programmable inter-word delay;
- a valid/ready handshake toward the external consumer;
- sticky overflow status and a level interrupt.

It sits on the SoC peripheral bus next to the other bus_if slaves.

## Interface
- DATA_W, 8: output word width, 1..32.
- DEPTH, 8: FIFO entries, power of two, ≥2.
- DELAY_W, 8: width of the DELAY register.
- DEFAULT_DELAY, 15: reset value of DELAY.
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- bus  bus_if.slave  –  req/gnt/we/addr/wdata/rdata/rvalid/err.
- parout_valid  out  1  word presented on parout.
- parout  out  DATA_W  output word; 0 when parout_valid=0.
- parout_ready  in  1  consumer accepts word when high with parout_valid.
- irq_o  out  1  level interrupt, registered.

## Operation
- Register map (addr[3:0]); unmapped reads return 0, unmapped writes are ignored.
- 0x0 CTRL, reset 0:
  - bit0 enable;
  - bit1 flush, write-1, self-clearing, reads 0;
  - bit2 irq_en.
- 0x4 DATA:
  - write pushes wdata[DATA_W-1:0] into the FIFO;
  - read returns the last word handed off on parout, zero-extended; reset 0.
- 0x8 STATUS, read-only except bit2:
  - bit0 empty;
  - bit1 full;
  - bit2 overflow (sticky; write 1 to clear);
  - bits[15:8] FIFO level.
- 0xC DELAY: DELAY_W bits, reset DEFAULT_DELAY. A new value takes effect at the next WAIT load; a running WAIT keeps its loaded count.
- Push when full: the word is dropped and overflow is set, unless a pop happens in the same cycle. In that case the push is accepted and the level is unchanged.
- Output FSM states:
  - IDLE → WAIT when enable && !empty; load cnt=DELAY.
  - WAIT: cnt==0 → PRESENT, else cnt−1.
  - PRESENT: parout_valid=1 and parout=FIFO head. On parout_ready, pop the head, copy it to the last-word register, go to IDLE.
- Clearing enable only blocks IDLE→WAIT. A word already in WAIT/PRESENT completes.
- Flush, on the cycle the write lands:
  - FIFO emptied;
  - FSM → IDLE;
  - overflow is not cleared.
  - Flush is the only case where parout_valid drops without a handshake. Flush has priority over a simultaneous push or pop.
- irq_o: registered irq_en && empty.
- bus.err is tied 0. bus.gnt = bus.req combinationally.

## Timing
- All outputs reset to 0 except STATUS.empty=1. FSM resets to IDLE, cnt to 0, DELAY to DEFAULT_DELAY.
- Reset at any point (mid-WAIT or mid-PRESENT) returns everything to reset values at that edge. Words in the FIFO are lost.
- Bus read: rvalid and rdata are registered, one cycle after req. The value reflects state before that cycle's edge.
- Bus write: effective at the edge ending the req cycle.
- Push at cycle N (FIFO empty, enable=1, FSM IDLE):
  - level=1 at N+1;
  - WAIT at N+2;
  - PRESENT at N+2+DELAY+1.
  - DELAY=0 gives parout_valid at N+3.
- After a handshake at cycle M with more data queued: next parout_valid at M+DELAY+3 (IDLE 1 cycle, WAIT DELAY+1 cycles).
- parout_valid and parout stay stable while parout_ready=0; flush and reset are the only exceptions.
- irq_o follows its condition with one cycle of latency.

## Structure
- Package parallel_out_pkg holds:
  - register offsets;
  - CTRL/STATUS bit positions;
  - the FSM state enum (IDLE, WAIT, PRESENT).
- Sub-module sync_fifo:
  - parameters DATA_W and DEPTH;
  - ports push, pop, flush, wdata, rdata (head, first-word-fall-through), full, empty, level[$clog2(DEPTH):0];
  - synchronous active-high reset.
- Top level holds the register file, the FSM, the delay counter and the bus read mux.

## Test plan
- Reset, then read CTRL/DATA/STATUS/DELAY → 0x0, 0x0, 0x1, 15; parout_valid=0; irq_o=0.
- CTRL=1, DELAY=0, write DATA=0xA5 at cycle N, parout_ready=1 → parout_valid=1 with parout=0xA5 at N+3 for one cycle. DATA then reads 0xA5 and STATUS reads 0x1.
- DELAY=4, enable=0, push 9 words into DEPTH=8 → STATUS full=1, overflow=1, level=8. Write 0x4 to STATUS → overflow=0. Set enable → the 8 words come out in order, spaced 7 cycles apart.
- parout_ready held 0 for 20 cycles in PRESENT → parout_valid and parout stable throughout. Raise ready → one pop.
- Full FIFO, push in the same cycle as a pop handshake → push accepted, level stays 8, overflow stays 0.
- Mid-WAIT write CTRL=0x3 (flush) → FIFO empty, FSM IDLE, no output. Separately, assert rst_i during PRESENT → parout_valid=0 at the next edge and all registers at reset values.
